// File: rtl/cpu_single_cycle.sv
// Single-cycle RV32I integer core: fetch, decode, execute and writeback of one
// instruction per clock. Holds its own instruction memory, PC register, 32x32
// register file and word-addressed data memory.
// Optional build macro: CPU_TRACE_EN prints one trace line per retired instruction.
module cpu_single_cycle #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_a0
);

    localparam int unsigned ImemAw = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DmemAw = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] instr;
    logic [31:0] rf_q [32];
    logic [31:0] dmem_q [DMEM_DEPTH];

    // PC register; instance name and register name are fixed so benches can probe them.
    if (1) begin : pc_item
        logic [31:0] next_pc;

        // Load RESET_PC on reset, otherwise follow the computed next PC.
        always_ff @(posedge clk) begin
            if (rst) begin
                next_pc <= RESET_PC;
            end else begin
                next_pc <= pc_d;
            end
        end
    end

    // Instruction memory; written only by benches through the hierarchy.
    if (1) begin : instr_memory_item
        logic [31:0] mem [IMEM_DEPTH];
    end

    assign pc = pc_item.next_pc;

    logic [ImemAw-1:0] imem_idx;
    assign imem_idx = ImemAw'({2'b00, pc[31:2]} % IMEM_DEPTH);
    assign instr    = instr_memory_item.mem[imem_idx];

    // Instruction fields and immediates.
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // Byte addresses; the low two bits are dropped so every access is a whole word.
    logic [31:0] ld_addr, st_addr;
    logic [DmemAw-1:0] ld_idx, st_idx;
    assign ld_addr = rs1_val + imm_i;
    assign st_addr = rs1_val + imm_s;
    assign ld_idx  = DmemAw'({2'b00, ld_addr[31:2]} % DMEM_DEPTH);
    assign st_idx  = DmemAw'({2'b00, st_addr[31:2]} % DMEM_DEPTH);

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub_sra,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = sub_sra ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = sub_sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        dmem_we;
    logic [31:0] pc_plus4;
    logic        imm_alt;

    assign pc_plus4 = pc + 32'd4;
    // Only SRAI uses bit 30 among immediate ALU ops; ADDI must never subtract.
    assign imm_alt  = (funct3 == 3'b101) && alt;

    // Decode and execute; unknown opcodes fall through as a NOP.
    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = 32'd0;
        dmem_we  = 1'b0;
        case (opcode)
            OpLui: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OpAuipc: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OpJal: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc + imm_j;
            end
            OpJalr: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = (rs1_val + imm_i) & ~32'd1;
            end
            OpBranch: begin
                if (br_taken(funct3, rs1_val, rs2_val)) begin
                    pc_d = pc + imm_b;
                end
            end
            OpLoad: begin
                rd_we    = 1'b1;
                rd_wdata = dmem_q[ld_idx];
            end
            OpStore: begin
                dmem_we = 1'b1;
            end
            OpImm: begin
                rd_we    = 1'b1;
                rd_wdata = alu(funct3, imm_alt, rs1_val, imm_i);
            end
            OpReg: begin
                rd_we    = 1'b1;
                rd_wdata = alu(funct3, alt, rs1_val, rs2_val);
            end
            default: ;
        endcase
    end

    // Register file write port; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rd_we && (rd != 5'd0)) begin
            rf_q[rd] <= rd_wdata;
        end
    end

    // Data memory store port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && dmem_we) begin
            dmem_q[st_idx] <= rs2_val;
        end
    end

`ifdef CPU_TRACE_EN
    // Simulation trace of each retired instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rd_we && (rd != 5'd0)) begin
                $display("pc=%h instr=%h rd=%0d wdata=%h", pc, instr, rd, rd_wdata);
            end else begin
                $display("pc=%h instr=%h", pc, instr);
            end
        end
    end
`else
`endif

    assign dbg_pc = pc;
    assign dbg_a0 = rf_q[10];

endmodule

// File: tb/tb_cpu_single_cycle.sv
// Scoreboard bench for cpu_single_cycle: stimulus loads programs, resets the core
// and queues hand-computed expectations tagged with the cycle they are due;
// a monitor checks them against the DUT on each falling edge.
module tb_cpu_single_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_a0;

    cpu_single_cycle dut (
        .clk    (clk),
        .rst    (rst),
        .dbg_pc (dbg_pc),
        .dbg_a0 (dbg_a0)
    );

    always #5 clk = ~clk;

    // sel: -1 = dbg_pc, -2 = dbg_a0, -3 = imem word 0, 0..31 = register xN
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   base   = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int k, input int sel, input logic [31:0] v,
                             input string nm);
        exp_t e;
        e.cyc  = base + k;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.instr_memory_item.mem[i] = 32'h0;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.instr_memory_item.mem[idx] = w;
    endtask

    task automatic load_branch_prog(input logic [31:0] w4);
        clear_imem();
        put(0, 32'h00500093);  // addi x1,x0,5
        put(1, 32'h00300113);  // addi x2,x0,3
        put(2, 32'h00000193);  // addi x3,x0,0
        put(3, 32'h001101b3);  // add  x3,x2,x1
        put(4, w4);            // addi x4,x0,8 or 9
        put(5, 32'h00418663);  // beq  x3,x4,+12
        put(6, 32'h00100513);  // addi x10,x0,1
        put(8, 32'h00000513);  // addi x10,x0,0
    endtask

    // Monitor: pops every expectation due at the current cycle and compares it.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.sel == -1) act = dbg_pc;
                else if (e.sel == -2) act = dbg_a0;
                else if (e.sel == -3) act = dut.instr_memory_item.mem[0];
                else act = dut.rf_q[e.sel];
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: check missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
                end else if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        int          pcs1 [8] = '{0, 4, 8, 12, 16, 20, 32, 36};
        int          pcs2 [10] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36};
        int          pcs4 [11] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 40, 48};

        // Branch taken: x3 == x4 == 8 skips the a0=1 write.
        load_branch_prog(32'h00800213);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            expect_at(k, -1, pcs1[k], "t1_pc");
            expect_at(k, -2, 32'h0, "t1_a0");
            if (k == 6) begin
                expect_at(k, 3, 32'd8, "t1_x3");
                expect_at(k, 4, 32'd8, "t1_x4");
            end
        end
        run(8);

        // Branch not taken: x4 = 9, a0 goes to 1 and is then cleared.
        put(4, 32'h00900213);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            expect_at(k, -1, pcs2[k], "t2_pc");
            expect_at(k, -2, (k == 7 || k == 8) ? 32'd1 : 32'd0, "t2_a0");
        end
        run(10);

        // x0 hard-wired, LUI, AUIPC.
        clear_imem();
        put(0, 32'h00700293);  // addi x5,x0,7
        put(1, 32'h00500013);  // addi x0,x0,5
        put(2, 32'h000002b3);  // add  x5,x0,x0
        put(3, 32'h123457b7);  // lui  x15,0x12345
        put(4, 32'h00001817);  // auipc x16,1 (pc 16)
        do_reset();
        expect_at(1, 5, 32'd7, "t3_x5_set");
        expect_at(2, 0, 32'd0, "t3_x0");
        expect_at(3, 5, 32'd0, "t3_x5_clr");
        expect_at(4, 15, 32'h12345000, "t3_lui");
        expect_at(5, 16, 32'h00001010, "t3_auipc");
        run(6);

        // ALU sign handling, shifts, signed/unsigned branches.
        clear_imem();
        put(0, 32'h00500093);   // addi x1,x0,5
        put(1, 32'h00300113);   // addi x2,x0,3
        put(2, 32'h401103b3);   // sub  x7,x2,x1
        put(3, 32'h00112433);   // slt  x8,x2,x1
        put(4, 32'h0013b4b3);   // sltu x9,x7,x1
        put(5, 32'h00100613);   // addi x12,x0,1
        put(6, 32'h40c3d6b3);   // sra  x13,x7,x12
        put(7, 32'h00c3d733);   // srl  x14,x7,x12
        put(8, 32'h0013c463);   // blt  x7,x1,+8
        put(10, 32'h0013f463);  // bgeu x7,x1,+8
        do_reset();
        for (int k = 0; k < 11; k++) begin
            expect_at(k, -1, pcs4[k], "t4_pc");
            if (k == 3) expect_at(k, 7, 32'hFFFFFFFE, "t4_sub");
            if (k == 4) expect_at(k, 8, 32'd1, "t4_slt");
            if (k == 5) expect_at(k, 9, 32'd0, "t4_sltu");
            if (k == 7) expect_at(k, 13, 32'hFFFFFFFF, "t4_sra");
            if (k == 8) expect_at(k, 14, 32'h7FFFFFFF, "t4_srl");
        end
        run(11);

        // Store/load, JAL, JALR with bit0 cleared, illegal opcode as NOP.
        clear_imem();
        put(0, 32'h00500093);  // addi x1,x0,5
        put(1, 32'h00102423);  // sw   x1,8(x0)
        put(2, 32'h00802303);  // lw   x6,8(x0)
        put(3, 32'h008000ef);  // jal  x1,+8
        put(4, 32'hffffffff);  // illegal -> NOP
        put(5, 32'h001082e7);  // jalr x5,1(x1)
        do_reset();
        expect_at(3, 6, 32'd5, "t5_lw");
        expect_at(4, -1, 32'd20, "t5_jal_pc");
        expect_at(4, 1, 32'd16, "t5_jal_link");
        expect_at(5, -1, 32'd16, "t5_jalr_pc");
        expect_at(5, 5, 32'd24, "t5_jalr_link");
        expect_at(6, -1, 32'd20, "t5_nop_pc");
        expect_at(6, 31, 32'd0, "t5_nop_x31");
        run(7);

        // Reset mid-program restarts from 0 with cleared registers.
        load_branch_prog(32'h00800213);
        do_reset();
        expect_at(3, 1, 32'd5, "t6_pre_x1");
        run(4);
        do_reset();
        expect_at(0, -1, 32'd0, "t6_rst_pc");
        expect_at(0, 1, 32'd0, "t6_rst_x1");
        expect_at(0, 2, 32'd0, "t6_rst_x2");
        expect_at(0, -3, 32'h00500093, "t6_imem_kept");
        expect_at(6, -1, 32'd32, "t6_rerun_pc");
        expect_at(6, 3, 32'd8, "t6_rerun_x3");
        run(8);

        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
